// File: rtl/arb_req_ctrl_if.sv
// arb_req_ctrl_if
// Bundles the signals between the job producers, the arb_req_ctrl front end
// and the downstream two-client arbiter.
//   job_valid[1:0]        producer -> ctrl : per-client push strobe
//   job_len[2*LEN_W-1:0]  producer -> ctrl : client i length at [i*LEN_W +: LEN_W]
//   job_ready[1:0]        ctrl -> producer : client i queue not full
//   request[1:0]          ctrl -> arbiter  : registered request
//   grant[1:0]            arbiter -> ctrl  : grant per client
//   beat[1:0]             ctrl -> producer : one beat transferred this cycle
//   done[1:0]             ctrl -> producer : pulse on a job's final beat
//   overflow[1:0]         ctrl -> producer : sticky dropped-push flag
// The master modport is the environment side (producers plus arbiter); the
// slave modport is the arb_req_ctrl side.
interface arb_req_ctrl_if #(
    parameter int LEN_W = 4
);
    logic [1:0]         job_valid;
    logic [2*LEN_W-1:0] job_len;
    logic [1:0]         job_ready;
    logic [1:0]         request;
    logic [1:0]         grant;
    logic [1:0]         beat;
    logic [1:0]         done;
    logic [1:0]         overflow;

    modport master (
        output job_valid, job_len, grant,
        input  job_ready, request, beat, done, overflow
    );

    modport slave (
        input  job_valid, job_len, grant,
        output job_ready, request, beat, done, overflow
    );
endinterface

// File: rtl/arb_req_ctrl.sv
// arb_req_ctrl
// Requester-side front end for a two-client arbiter. Each client owns a job
// FIFO, a request FSM and a beat down-counter. A queued job is popped, its
// request is raised and held until granted, granted beats are counted down,
// and the request is dropped for one release cycle after the final beat.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : arb_req_ctrl_if.slave (job push side, request/grant side, status)
module arb_req_ctrl #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    arb_req_ctrl_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_REL  = 2'd3
    } state_t;

    logic ready_s    [2];
    logic request_s  [2];
    logic beat_s     [2];
    logic done_s     [2];
    logic overflow_s [2];

    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [LEN_W-1:0] mem_q [DEPTH];
        logic [AW:0]      wr_ptr_q, wr_ptr_d;
        logic [AW:0]      rd_ptr_q, rd_ptr_d;
        state_t           state_q, state_d;
        logic [LEN_W-1:0] cnt_q, cnt_d;
        logic             request_q, request_d;
        logic             overflow_q, overflow_d;
        logic             full_s, empty_s, push_s;
        logic             beat_ch_s, done_ch_s;
        logic [LEN_W-1:0] len_in_s, head_s;

        // Extra pointer MSB separates a full queue from an empty one.
        assign full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        assign empty_s  = (wr_ptr_q == rd_ptr_q);
        // Readiness is based on start-of-cycle occupancy, so a same-cycle
        // pop never lets a push into a full queue.
        assign push_s   = bus.job_valid[i] & ~full_s;
        assign len_in_s = bus.job_len[i*LEN_W +: LEN_W];
        assign head_s   = mem_q[rd_ptr_q[AW-1:0]];

        // Next-state, counter, pointer and status computation for this client.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            rd_ptr_d   = rd_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            beat_ch_s  = 1'b0;
            done_ch_s  = 1'b0;
            overflow_d = overflow_q | (bus.job_valid[i] & full_s);

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!empty_s) begin
                        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
                        cnt_d    = head_s;
                        state_d  = ST_REQ;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.grant[i]) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_XFER: begin
                    if (bus.grant[i]) begin
                        beat_ch_s = 1'b1;
                        // A beat taken with the counter at zero is the last one.
                        if (cnt_q == '0) begin
                            done_ch_s = 1'b1;
                            state_d   = ST_REL;
                        end else begin
                            cnt_d     = cnt_q - LEN_W'(1);
                        end
                    end else begin
                        state_d = ST_XFER;
                    end
                end
                ST_REL: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            request_d = (state_d == ST_REQ) || (state_d == ST_XFER);
        end

        // Control state registers with synchronous reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                request_q  <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                request_q  <= request_d;
                overflow_q <= overflow_d;
            end
        end

        // Queue storage; no reset needed since the pointers define validity.
        always_ff @(posedge clk) begin
            if (push_s && !rst) begin
                mem_q[wr_ptr_q[AW-1:0]] <= len_in_s;
            end
        end

        assign ready_s[i]    = ~full_s;
        assign request_s[i]  = request_q;
        assign beat_s[i]     = beat_ch_s;
        assign done_s[i]     = done_ch_s;
        assign overflow_s[i] = overflow_q;
    end

    assign bus.job_ready = {ready_s[1],    ready_s[0]};
    assign bus.request   = {request_s[1],  request_s[0]};
    assign bus.beat      = {beat_s[1],     beat_s[0]};
    assign bus.done      = {done_s[1],     done_s[0]};
    assign bus.overflow  = {overflow_s[1], overflow_s[0]};

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Directed testbench for arb_req_ctrl (DEPTH=4, LEN_W=4).
module tb_arb_req_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    arb_req_ctrl_if #(.LEN_W(4)) bus ();

    arb_req_ctrl #(.DEPTH(4), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next cycle and apply that cycle's inputs away from the edge.
    task automatic step(input logic r, input logic [1:0] v, input logic [7:0] len,
                        input logic [1:0] g);
        @(posedge clk);
        #1;
        rst           = r;
        bus.job_valid = v;
        bus.job_len   = len;
        bus.grant     = g;
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] z(input logic [1:0] x);
        return {6'd0, x};
    endfunction

    initial begin
        logic [1:0] g_tab [5];
        logic [1:0] b_tab [5];
        logic [1:0] d_tab [5];
        logic [1:0] rq_tab [7];
        logic [1:0] dn_tab [7];
        logic [1:0] rdy_tab [6];
        int beats;
        int seen_done;

        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.job_valid = 2'b00;
        bus.job_len   = 8'h00;
        bus.grant     = 2'b00;
        // Push during reset must be discarded.
        step(1'b1, 2'b11, 8'h00, 2'b00);
        step(1'b1, 2'b00, 8'h00, 2'b00);

        // Reset state.
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("rst_request",  z(bus.request),   8'h00);
        chk("rst_beat",     z(bus.beat),      8'h00);
        chk("rst_done",     z(bus.done),      8'h00);
        chk("rst_overflow", z(bus.overflow),  8'h00);
        chk("rst_ready",    z(bus.job_ready), 8'h03);
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("rst_push_dropped", z(bus.request), 8'h00);

        // Single-beat job on client0.
        step(1'b0, 2'b01, 8'h00, 2'b00);   // push
        step(1'b0, 2'b00, 8'h00, 2'b00);   // pop
        chk("t1_req_n1", z(bus.request), 8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("t1_req_n2", z(bus.request), 8'h01);
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("t1_req_hold", z(bus.request), 8'h01);
        step(1'b0, 2'b00, 8'h00, 2'b01);   // grant seen in REQ
        chk("t1_no_beat_in_req", z(bus.beat), 8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b01);
        chk("t1_beat", z(bus.beat), 8'h01);
        chk("t1_done", z(bus.done), 8'h01);
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("t1_req_rel", z(bus.request), 8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b00);

        // Four-beat job with a grant stall.
        step(1'b0, 2'b01, 8'h03, 2'b00);   // push
        step(1'b0, 2'b00, 8'h00, 2'b00);   // pop
        step(1'b0, 2'b00, 8'h00, 2'b01);   // REQ with grant
        chk("t2_req", z(bus.request), 8'h01);
        g_tab = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
        b_tab = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01};
        d_tab = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 2'b00, 8'h00, g_tab[k]);
            chk($sformatf("t2_beat%0d", k), z(bus.beat), z(b_tab[k]));
            chk($sformatf("t2_done%0d", k), z(bus.done), z(d_tab[k]));
            chk($sformatf("t2_req%0d", k),  z(bus.request), 8'h01);
        end
        step(1'b0, 2'b00, 8'h00, 2'b01);   // REL: grant ignored
        chk("t2_rel_req",  z(bus.request), 8'h00);
        chk("t2_rel_beat", z(bus.beat),    8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b00);

        // Client1 fill: first push is popped into REQ, then four more fill the
        // queue, and the sixth is dropped.
        rdy_tab = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 2'b10, {4'(k + 1), 4'h0}, 2'b00);
            chk($sformatf("t3_ready%0d", k), z(bus.job_ready), z(rdy_tab[k]));
        end
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("t3_overflow", z(bus.overflow),  8'h02);
        chk("t3_full",     z(bus.job_ready), 8'h01);
        chk("t3_req",      z(bus.request),   8'h02);
        step(1'b1, 2'b00, 8'h00, 2'b00);
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("t3_rst_overflow", z(bus.overflow),  8'h00);
        chk("t3_rst_ready",    z(bus.job_ready), 8'h03);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b00, 8'h00, 2'b00);
            chk($sformatf("t3_flushed%0d", k), z(bus.request), 8'h00);
        end

        // Both clients, len=1, granted client0 then client1.
        step(1'b0, 2'b11, 8'h11, 2'b00);   // push both
        step(1'b0, 2'b00, 8'h00, 2'b00);   // pop both
        step(1'b0, 2'b00, 8'h00, 2'b01);
        chk("t4_req_both", z(bus.request), 8'h03);
        step(1'b0, 2'b00, 8'h00, 2'b01);
        chk("t4_b0_1", z(bus.beat), 8'h01);
        chk("t4_d0_1", z(bus.done), 8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b01);
        chk("t4_b0_2", z(bus.beat), 8'h01);
        chk("t4_d0_2", z(bus.done), 8'h01);
        step(1'b0, 2'b00, 8'h00, 2'b10);
        chk("t4_req_c1", z(bus.request), 8'h02);
        chk("t4_nobeat", z(bus.beat),    8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b10);
        chk("t4_b1_1", z(bus.beat), 8'h02);
        chk("t4_d1_1", z(bus.done), 8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b10);
        chk("t4_b1_2", z(bus.beat), 8'h02);
        chk("t4_d1_2", z(bus.done), 8'h02);
        step(1'b0, 2'b00, 8'h00, 2'b00);
        chk("t4_req_end", z(bus.request), 8'h00);
        step(1'b0, 2'b00, 8'h00, 2'b00);

        // Reset mid-XFER on client0 with a second job queued.
        step(1'b0, 2'b01, 8'h05, 2'b00);
        step(1'b0, 2'b01, 8'h02, 2'b00);
        step(1'b0, 2'b00, 8'h00, 2'b01);
        step(1'b0, 2'b00, 8'h00, 2'b01);
        chk("t5_in_xfer", z(bus.beat), 8'h01);
        step(1'b1, 2'b00, 8'h00, 2'b01);
        step(1'b0, 2'b00, 8'h00, 2'b01);
        chk("t5_request",  z(bus.request),   8'h00);
        chk("t5_beat",     z(bus.beat),      8'h00);
        chk("t5_done",     z(bus.done),      8'h00);
        chk("t5_overflow", z(bus.overflow),  8'h00);
        chk("t5_ready",    z(bus.job_ready), 8'h03);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b00, 8'h00, 2'b00);
            chk($sformatf("t5_gone%0d", k), z(bus.request), 8'h00);
        end

        // Back-to-back single-beat jobs with continuous grant.
        step(1'b0, 2'b01, 8'h00, 2'b01);
        step(1'b0, 2'b01, 8'h00, 2'b01);
        rq_tab = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        dn_tab = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 2'b00, 8'h00, 2'b01);
            chk($sformatf("t6_req%0d", k),  z(bus.request), z(rq_tab[k]));
            chk($sformatf("t6_done%0d", k), z(bus.done),    z(dn_tab[k]));
        end

        // All-ones length gives 16 beats.
        step(1'b0, 2'b01, 8'h0F, 2'b01);
        beats     = 0;
        seen_done = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 2'b00, 8'h00, 2'b01);
            if (bus.beat[0] === 1'b1) beats++;
            if (bus.done[0] === 1'b1) begin
                seen_done = 1;
                break;
            end
        end
        chk("t7_done_seen", 8'(seen_done), 8'd1);
        chk("t7_beats",     8'(beats),     8'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
